// File: rtl/sqrt_pkg.sv
// Shared widths, result payload and FSM encoding for the sqrt request front-end.
package sqrt_pkg;

  localparam int unsigned OPERAND_W = 16;
  localparam int unsigned ROOT_W    = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic              timeout;
    logic              error;
    logic [ROOT_W-1:0] root;
  } seq_res_t;

endpackage

// File: rtl/sqrt_req_fifo.sv
// Synchronous operand FIFO; power-of-two depth, registered full/empty flags.
module sqrt_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] head_c,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && !full_q;
  assign do_pop  = pop_i && !empty_q;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_c  = mem_q[rd_ptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;

endmodule

// File: rtl/sqrt_req_sequencer.sv
// Request front-end for sqrt_calculator: buffers operands, runs one core op at a time.
// Define SQRT_SEQ_STATS_EN to add saturating ok/error/timeout result counters.
module sqrt_req_sequencer
  import sqrt_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OPERAND_W-1:0] in_data,
  output logic                 core_start,
  output logic [OPERAND_W-1:0] core_in,
  input  logic [ROOT_W-1:0]    core_out,
  input  logic                 core_error,
  input  logic                 core_done,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ROOT_W-1:0]    res_root,
  output logic                 res_error,
  output logic                 res_timeout,
  output logic                 busy
`ifdef SQRT_SEQ_STATS_EN
  ,
  output logic [15:0]          stat_ok_cnt,
  output logic [15:0]          stat_err_cnt,
  output logic [15:0]          stat_to_cnt
`endif
);

  localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_t           state_q, state_d;
  logic [OPERAND_W-1:0] op_q, op_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  seq_res_t             res_q, res_d;
  logic                 res_valid_q, res_valid_d;
  logic                 core_start_q, core_start_d;

  logic                 fifo_pop;
  logic [OPERAND_W-1:0] fifo_head;
  logic                 fifo_full;
  logic                 fifo_empty;

  sqrt_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (OPERAND_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (in_valid),
    .pop_i   (fifo_pop),
    .data_i  (in_data),
    .head_c  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Zero operands bypass the core entirely to avoid its divide-by-zero.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    timer_d      = timer_q;
    res_d        = res_q;
    res_valid_d  = res_valid_q;
    core_start_d = 1'b0;
    fifo_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          op_d     = fifo_head;
          if (fifo_head == '0) begin
            res_d       = '0;
            res_valid_d = 1'b1;
            state_d     = HOLD;
          end else begin
            core_start_d = 1'b1;
            state_d      = ISSUE;
          end
        end
      end
      ISSUE: begin
        timer_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (core_done) begin
          res_d.timeout = 1'b0;
          res_d.error   = core_error;
          res_d.root    = core_error ? '0 : core_out;
          res_valid_d   = 1'b1;
          state_d       = HOLD;
        end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
          res_d         = '0;
          res_d.timeout = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = HOLD;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_d       = '0;
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      op_q         <= '0;
      timer_q      <= '0;
      res_q        <= '0;
      res_valid_q  <= 1'b0;
      core_start_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      timer_q      <= timer_d;
      res_q        <= res_d;
      res_valid_q  <= res_valid_d;
      core_start_q <= core_start_d;
    end
  end

  assign in_ready    = !fifo_full;
  assign core_start  = core_start_q;
  assign core_in     = op_q;
  assign res_valid   = res_valid_q;
  assign res_root    = res_q.root;
  assign res_error   = res_q.error;
  assign res_timeout = res_q.timeout;
  assign busy        = (state_q != IDLE) || !fifo_empty;

`ifdef SQRT_SEQ_STATS_EN
  logic [15:0] ok_cnt_q;
  logic [15:0] err_cnt_q;
  logic [15:0] to_cnt_q;
  logic        res_hs;

  assign res_hs = res_valid_q && res_ready;

  // Zero-operand results carry neither flag, so they land in the ok class.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
      to_cnt_q  <= '0;
    end else if (res_hs) begin
      if (res_q.timeout) begin
        if (to_cnt_q != 16'hFFFF) to_cnt_q <= to_cnt_q + 16'd1;
      end else if (res_q.error) begin
        if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
      end else begin
        if (ok_cnt_q != 16'hFFFF) ok_cnt_q <= ok_cnt_q + 16'd1;
      end
    end
  end

  assign stat_ok_cnt  = ok_cnt_q;
  assign stat_err_cnt = err_cnt_q;
  assign stat_to_cnt  = to_cnt_q;
`endif

endmodule

// File: tb/tb_sqrt_req_sequencer.sv
// Directed bench for sqrt_req_sequencer with a behavioural core and a result scoreboard.
module tb_sqrt_req_sequencer;
  import sqrt_pkg::*;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned TIMEOUT    = 32;
  localparam int OK_LAT  = 12;
  localparam int ERR_LAT = 2;
  // Cycles from the start-pulse cycle to the first cycle with res_valid=1.
  localparam int LAT_OK  = OK_LAT + 2;
  localparam int LAT_ERR = ERR_LAT + 2;
  localparam int LAT_TO  = TIMEOUT + 1;
  localparam int M_NORM = 0;
  localparam int M_TO   = 1;
  localparam int M_NONE = 2;

  typedef struct {
    logic [7:0] root;
    logic       err;
    logic       to;
    int         lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        core_start;
  logic [15:0] core_in;
  logic [7:0]  core_out;
  logic        core_error;
  logic        core_done;
  logic        res_valid;
  logic        res_ready;
  logic [7:0]  res_root;
  logic        res_error;
  logic        res_timeout;
  logic        busy;
`ifdef SQRT_SEQ_STATS_EN
  logic [15:0] stat_ok_cnt, stat_err_cnt, stat_to_cnt;
`endif

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc = 0;
  int   last_start = 0;
  int   start_cnt = 0;
  int   rise_lat = 0;
  logic prev_valid = 1'b0;
  logic stub_hang = 1'b0;
  int   s0;

  sqrt_req_sequencer #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .core_start  (core_start),
    .core_in     (core_in),
    .core_out    (core_out),
    .core_error  (core_error),
    .core_done   (core_done),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_root    (res_root),
    .res_error   (res_error),
    .res_timeout (res_timeout),
    .busy        (busy)
`ifdef SQRT_SEQ_STATS_EN
    ,
    .stat_ok_cnt  (stat_ok_cnt),
    .stat_err_cnt (stat_err_cnt),
    .stat_to_cnt  (stat_to_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int isqrt(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  function automatic exp_t expect_for(input logic [15:0] d);
    exp_t e;
    e.to = 1'b0;
    if (d == 16'd0) begin
      e.root = 8'd0; e.err = 1'b0; e.lat = 0;
    end else if (d[15]) begin
      e.root = 8'd0; e.err = 1'b1; e.lat = LAT_ERR;
    end else begin
      e.root = 8'(isqrt(int'(d))); e.err = 1'b0; e.lat = LAT_OK;
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural core: done is registered and cleared at the start edge; error results carry junk root.
  logic [15:0] m_op;
  int          m_cnt;
  logic        m_busy;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_done <= 1'b0; core_error <= 1'b0; core_out <= 8'd0;
      m_busy <= 1'b0; m_cnt <= 0; m_op <= 16'd0;
    end else if (core_start) begin
      core_done <= 1'b0; core_error <= 1'b0; core_out <= 8'd0;
      m_op   <= core_in;
      m_cnt  <= core_in[15] ? ERR_LAT - 1 : OK_LAT - 1;
      m_busy <= !stub_hang;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_busy     <= 1'b0;
        core_done  <= 1'b1;
        core_error <= m_op[15];
        core_out   <= m_op[15] ? 8'hA5 : 8'(isqrt(int'(m_op)));
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  // Result monitor and scoreboard consumer.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (core_start) begin
        last_start = cyc;
        start_cnt++;
        chk("start_while_valid", 32'(res_valid), 32'd0);
      end
      if (res_valid && !prev_valid) rise_lat = cyc - last_start;
      prev_valid = res_valid;
      if (res_valid && res_ready) begin
        n_checks++;
        assert (sb_q.size() > 0) else begin
          n_fail++;
          $error("FAIL sb_underflow observed=root %0h expected=no result", res_root);
        end
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          chk("res_root", 32'(res_root), 32'(e.root));
          chk("res_error", 32'(res_error), 32'(e.err));
          chk("res_timeout", 32'(res_timeout), 32'(e.to));
          if (e.lat > 0) chk("latency", 32'(rise_lat), 32'(e.lat));
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_core_start"}, 32'(core_start), 32'd0);
    chk({tag, "_core_in"}, 32'(core_in), 32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_res_root"}, 32'(res_root), 32'd0);
    chk({tag, "_res_error"}, 32'(res_error), 32'd0);
    chk({tag, "_res_timeout"}, 32'(res_timeout), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic push(input logic [15:0] d, input int mode);
    exp_t e;
    bit   ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("push_accept", 32'(ok), 32'd1);
    if (ok && mode == M_NORM) sb_q.push_back(expect_for(d));
    if (ok && mode == M_TO) begin
      e.root = 8'd0; e.err = 1'b0; e.to = 1'b1; e.lat = LAT_TO;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain(input string tag, input int bound);
    for (int i = 0; i < bound; i++) begin
      if (sb_q.size() == 0) break;
      @(posedge clk); #1;
    end
    chk({tag, "_drain"}, 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = 16'd0; res_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Single positive operand through the core.
    res_ready = 1'b1;
    s0 = start_cnt;
    push(16'd144, M_NORM);
    drain("op144", 200);
    chk("start_cnt_144", 32'(start_cnt - s0), 32'd1);

    // Negative operand: error, root forced to 0.
    s0 = start_cnt;
    push(16'h8000, M_NORM);
    drain("op8000", 200);
    chk("start_cnt_8000", 32'(start_cnt - s0), 32'd1);

    // Zero operand never reaches the core.
    s0 = start_cnt;
    push(16'd0, M_NORM);
    drain("op0", 200);
    chk("start_cnt_0", 32'(start_cnt - s0), 32'd0);

    // Back-pressure: one op in HOLD, FIFO fills to full behind it.
    res_ready = 1'b0;
    push(16'd16, M_NORM);
    push(16'd25, M_NORM);
    push(16'd36, M_NORM);
    push(16'd49, M_NORM);
    push(16'd64, M_NORM);
    for (int i = 0; i < 100; i++) begin
      if (res_valid) break;
      @(posedge clk); #1;
    end
    chk("hold_valid_seen", 32'(res_valid), 32'd1);
    s0 = start_cnt;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_valid", 32'(res_valid), 32'd1);
      chk("hold_root", 32'(res_root), 32'd4);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1;
    chk("hold_no_start", 32'(start_cnt - s0), 32'd0);
    res_ready = 1'b1;
    push(16'd81, M_NORM);
    drain("full_fifo", 400);

    // Core that never completes: timeout.
    stub_hang = 1'b1;
    push(16'd100, M_TO);
    drain("timeout", 200);

    // Reset while the next request sits in WAIT with another queued.
    push(16'd200, M_NONE);
    push(16'd300, M_NONE);
    repeat (6) @(posedge clk);
    #1;
    chk("midwait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check_reset_values("midwait_rst");
    s0 = start_cnt;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_res_valid", 32'(res_valid), 32'd0);
    chk("post_rst_no_start", 32'(start_cnt - s0), 32'd0);

    // Normal operation resumes after reset.
    stub_hang = 1'b0;
    push(16'd49, M_NORM);
    drain("post_rst_op", 200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
